prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_pkg.sv | 23 ++
 rtl/prog_counter_presc.sv | 30 +++
 rtl/prog_counter.sv | 104 ++++++++++
 tb/tb_prog_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared mode encodings, FSM state type and mode decode helpers for the
// programmable counter.
package prog_counter_pkg;

  localparam logic [1:0] MODE_UP_WRAP      = 2'b00;
  localparam logic [1:0] MODE_DOWN_WRAP    = 2'b01;
  localparam logic [1:0] MODE_UP_ONESHOT   = 2'b10;
  localparam logic [1:0] MODE_DOWN_ONESHOT = 2'b11;

  typedef enum logic {
    ARMED = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic logic is_down(input logic [1:0] m);
    return m[0];
  endfunction

  function automatic logic is_oneshot(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/prog_counter_presc.sv
// Prescaler: emits one tick per prescale+1 enabled cycles; clr restarts the
// phase so a load lines up the next step with a full prescale period.
module prog_counter_presc #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  w_hit;

  assign w_hit = (r_pcnt == prescale);
  assign tick  = en & w_hit & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (clr) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_hit ? '0 : r_pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap or one-shot terminal behaviour,
// prescaled stepping, synchronous load and a sticky terminal-count flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_sticky,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  wrap_sticky,
  output logic                  running
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_sticky, w_sticky_nxt;
  logic             r_running, w_running_nxt;
  logic             w_tick;
  logic             w_terminal;

  prog_counter_presc #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Up mode treats anything at or above limit as terminal so a loaded
  // out-of-range value still wraps back into 0..limit.
  assign w_terminal = is_down(mode) ? (r_out == '0) : (r_out >= limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = ARMED;
    end else if (r_state == DONE) begin
      if (!is_oneshot(mode)) w_state_nxt = ARMED;
    end else if (w_tick && w_terminal && is_oneshot(mode)) begin
      w_state_nxt = DONE;
    end
  end

  always_comb begin
    w_out_nxt = r_out;
    w_tc_nxt  = 1'b0;
    if (load) begin
      w_out_nxt = load_val;
    end else if (r_state == ARMED && w_tick) begin
      if (w_terminal) begin
        w_tc_nxt = 1'b1;
        // One-shot parks on the terminal value; wrap jumps to the far end.
        if (is_oneshot(mode)) w_out_nxt = is_down(mode) ? '0 : limit;
        else                  w_out_nxt = is_down(mode) ? limit : '0;
      end else begin
        w_out_nxt = is_down(mode) ? r_out - WIDTH'(1) : r_out + WIDTH'(1);
      end
    end
    w_sticky_nxt  = w_tc_nxt | (r_sticky & ~clr_sticky);
    w_running_nxt = en & (w_state_nxt == ARMED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_tc      <= 1'b0;
      r_sticky  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_out     <= w_out_nxt;
      r_tc      <= w_tc_nxt;
      r_sticky  <= w_sticky_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign out         = r_out;
  assign tc          = r_tc;
  assign wrap_sticky = r_sticky;
  assign running     = r_running;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: hand-computed vectors for wrap, one-shot,
// prescale, enable gating, sticky flag and reset priority.
module tb_prog_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic        load;
  logic [31:0] load_val;
  logic [31:0] limit;
  logic [7:0]  prescale;
  logic        clr_sticky;
  logic [31:0] out;
  logic        tc;
  logic        wrap_sticky;
  logic        running;

  int checks   = 0;
  int failures = 0;

  prog_counter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .load        (load),
    .load_val    (load_val),
    .limit       (limit),
    .prescale    (prescale),
    .clr_sticky  (clr_sticky),
    .out         (out),
    .tc          (tc),
    .wrap_sticky (wrap_sticky),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e_out, input logic e_tc,
                            input logic e_st, input logic e_run);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".tc"}, {31'd0, tc}, {31'd0, e_tc});
    chk({tag, ".sticky"}, {31'd0, wrap_sticky}, {31'd0, e_st});
    chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
  endtask

  initial begin
    logic [31:0] exp_out_034 [1:9];
    exp_out_034 = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2};

    // Reset, then up-wrap limit 3
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;
    limit = 32'd3; prescale = 8'd0; clr_sticky = 1'b0;
    step();
    expect_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); expect_all("upw1", 32'd1, 1'b0, 1'b0, 1'b1);
    step(); expect_all("upw2", 32'd2, 1'b0, 1'b0, 1'b1);
    step(); expect_all("upw3", 32'd3, 1'b0, 1'b0, 1'b1);
    step(); expect_all("upw_wrap", 32'd0, 1'b1, 1'b1, 1'b1);
    step(); expect_all("upw_after", 32'd1, 1'b0, 1'b1, 1'b1);

    // Down-wrap from a loaded 2, limit 5; load also clears sticky
    mode = 2'b01; limit = 32'd5; load = 1'b1; load_val = 32'd2; clr_sticky = 1'b1;
    step(); expect_all("dnw_load", 32'd2, 1'b0, 1'b0, 1'b1);
    load = 1'b0; clr_sticky = 1'b0;
    step(); expect_all("dnw1", 32'd1, 1'b0, 1'b0, 1'b1);
    step(); expect_all("dnw0", 32'd0, 1'b0, 1'b0, 1'b1);
    step(); expect_all("dnw_wrap", 32'd5, 1'b1, 1'b1, 1'b1);
    step(); expect_all("dnw4", 32'd4, 1'b0, 1'b1, 1'b1);

    // Sticky clear alone, then clear colliding with a set
    clr_sticky = 1'b1;
    step(); expect_all("clr_alone", 32'd3, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b0;
    step(); step(); step();
    expect_all("dn_to0", 32'd0, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step(); expect_all("clr_vs_set", 32'd5, 1'b1, 1'b1, 1'b1);
    step(); expect_all("clr_next", 32'd4, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b0;

    // Up one-shot, limit 2, prescale 2
    mode = 2'b10; limit = 32'd2; prescale = 8'd2; load = 1'b1; load_val = 32'd0;
    step(); expect_all("os_load", 32'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      expect_all($sformatf("os_e%0d", i), exp_out_034[i], (i == 9), (i == 9), (i != 9));
    end
    for (int i = 10; i <= 12; i++) begin
      step();
      expect_all($sformatf("os_hold%0d", i), 32'd2, 1'b0, 1'b1, 1'b0);
    end
    load = 1'b1; load_val = 32'd0;
    step(); expect_all("os_rearm", 32'd0, 1'b0, 1'b1, 1'b1);
    load = 1'b0;

    // Enable gap mid-prescale, prescale 3
    mode = 2'b00; limit = 32'd100; prescale = 8'd3; load = 1'b1; load_val = 32'd0;
    step(); expect_all("en_load", 32'd0, 1'b0, 1'b1, 1'b1);
    load = 1'b0;
    step(); step();
    expect_all("en_e2", 32'd0, 1'b0, 1'b1, 1'b1);
    en = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      step();
      expect_all($sformatf("en_off%0d", i), 32'd0, 1'b0, 1'b1, 1'b0);
    end
    en = 1'b1;
    step(); expect_all("en_e7", 32'd0, 1'b0, 1'b1, 1'b1);
    step(); expect_all("en_e8", 32'd1, 1'b0, 1'b1, 1'b1);
    step(); step(); step();
    expect_all("en_e11", 32'd1, 1'b0, 1'b1, 1'b1);
    step(); expect_all("en_e12", 32'd2, 1'b0, 1'b1, 1'b1);

    // Down one-shot, then re-arm by switching to a wrap mode
    mode = 2'b11; limit = 32'd5; prescale = 8'd0; load = 1'b1; load_val = 32'd1;
    step(); expect_all("dos_load", 32'd1, 1'b0, 1'b1, 1'b1);
    load = 1'b0;
    step(); expect_all("dos0", 32'd0, 1'b0, 1'b1, 1'b1);
    step(); expect_all("dos_term", 32'd0, 1'b1, 1'b1, 1'b0);
    step(); expect_all("dos_hold", 32'd0, 1'b0, 1'b1, 1'b0);
    mode = 2'b01;
    step(); expect_all("dos_rearm", 32'd0, 1'b0, 1'b1, 1'b1);
    step(); expect_all("dos_wrap", 32'd5, 1'b1, 1'b1, 1'b1);

    // Loaded value above limit in up-wrap
    mode = 2'b00; limit = 32'd3; load = 1'b1; load_val = 32'd10;
    step(); expect_all("big_load", 32'd10, 1'b0, 1'b1, 1'b1);
    load = 1'b0;
    step(); expect_all("big_wrap", 32'd0, 1'b1, 1'b1, 1'b1);

    // Reset overrides a simultaneous load
    load = 1'b1; load_val = 32'd7;
    step(); expect_all("pre_rst", 32'd7, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0; load = 1'b1; load_val = 32'd9;
    step(); expect_all("rst_load", 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; load = 1'b0;

    // limit 0 in up-wrap: tc every tick, out stays 0
    mode = 2'b00; limit = 32'd0; prescale = 8'd0;
    step(); expect_all("lim0_a", 32'd0, 1'b1, 1'b1, 1'b1);
    step(); expect_all("lim0_b", 32'd0, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
